exe_unit_arb: RTL and testbench

EXE_UNIT_ARB -- requirements
Module: exe_unit_arb

---
 rtl/exe_pkg.sv | 10 +
 rtl/exe_unit_w6.sv | 41 ++++
 rtl/rr_arb2.sv | 15 +
 rtl/exe_unit_arb.sv | 110 +++++++++++
 tb/tb_exe_unit_arb.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_pkg.sv
// exe_pkg: opcodes, status width and arbiter FSM states shared by the exe_unit_arb slice
package exe_pkg;
    localparam logic [1:0] OP_SUB = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_SHF = 2'b10;
    localparam logic [1:0] OP_BIT = 2'b11;
    localparam int STATUS_W = 4;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/exe_unit_w6.sv
// exe_unit_w6: sub/cmp/shift/bit-toggle unit with {N,Z,C,V} status and EXE_LAT-deep output pipeline
module exe_unit_w6 import exe_pkg::*; #(
    parameter int BITS    = 8,
    parameter int EXE_LAT = 1
) (
    input  logic                i_clk,
    input  logic [BITS-1:0]     i_a,
    input  logic [BITS-1:0]     i_b,
    input  logic [1:0]          i_op,
    output logic [BITS-1:0]     o_out,
    output logic [STATUS_W-1:0] o_status
);
    localparam int SW = $clog2(BITS);
    logic [BITS:0]         diff;
    logic [BITS-1:0]       res, flg;
    logic [SW-1:0]         sh;
    logic [STATUS_W-1:0]   st;
    logic                  ovf;
    logic [BITS-1:0]       out_q [EXE_LAT];
    logic [STATUS_W-1:0]   st_q [EXE_LAT];
    always_comb begin
        diff = {1'b0, i_a} - {1'b0, i_b};
        sh = i_b[SW-1:0];
        ovf = (i_a[BITS-1] != i_b[BITS-1]) && (diff[BITS-1] != i_a[BITS-1]);
        res = i_op == OP_SUB ? diff[BITS-1:0] : i_op == OP_CMP ? BITS'(diff[BITS]) :
              i_op == OP_SHF ? i_a << sh : i_a ^ (BITS'(1) << sh);
        // sub and cmp flag the difference; shift and bit-change flag the result
        flg = i_op[1] ? res : diff[BITS-1:0];
        st = {flg[BITS-1], ~|flg, ~i_op[1] & diff[BITS], ~i_op[1] & ovf};
    end
    always_ff @(posedge i_clk) begin
        out_q[0] <= res;
        st_q[0] <= st;
        for (int k = 1; k < EXE_LAT; k++) begin
            out_q[k] <= out_q[k-1];
            st_q[k] <= st_q[k-1];
        end
    end
    assign o_out = out_q[EXE_LAT-1];
    assign o_status = st_q[EXE_LAT-1];
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin select; the pointer names the requester favoured on contention
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);
    logic ptr_q, ptr_d;
    always_comb begin
        gnt_o = !en_i ? 2'b00 : &req_i ? (ptr_q ? 2'b10 : 2'b01) : req_i;
        ptr_d = |gnt_o ? gnt_o[0] : ptr_q;
    end
    always_ff @(posedge clk_i) ptr_q <= rst_i ? 1'b0 : ptr_d;
endmodule

// File: rtl/exe_unit_arb.sv
// exe_unit_arb: round-robin front end sharing one exe_unit_w6 between two requesters, one op in flight
module exe_unit_arb import exe_pkg::*; #(
    parameter int BITS    = 8,
    parameter int EXE_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req0_valid,
    output logic                o_req0_ready,
    input  logic [BITS-1:0]     i_req0_a,
    input  logic [BITS-1:0]     i_req0_b,
    input  logic [1:0]          i_req0_op,
    input  logic                i_req1_valid,
    output logic                o_req1_ready,
    input  logic [BITS-1:0]     i_req1_a,
    input  logic [BITS-1:0]     i_req1_b,
    input  logic [1:0]          i_req1_op,
    output logic                o_rsp0_valid,
    output logic                o_rsp1_valid,
    input  logic                i_rsp0_ready,
    input  logic                i_rsp1_ready,
    output logic [BITS-1:0]     o_rsp_out,
    output logic [STATUS_W-1:0] o_rsp_status,
    output logic [BITS-1:0]     o_exe_a,
    output logic [BITS-1:0]     o_exe_b,
    output logic [1:0]          o_exe_op,
    input  logic [BITS-1:0]     i_exe_out,
    input  logic [STATUS_W-1:0] i_exe_status,
    output logic                o_busy
);
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                gid_q, gid_d;
    logic [1:0]          gnt;
    logic [BITS-1:0]     a_q, a_d, b_q, b_d, out_q, out_d;
    logic [1:0]          op_q, op_d;
    logic [STATUS_W-1:0] st_q, st_d;

    rr_arb2 u_rr (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .req_i ({i_req1_valid, i_req0_valid}),
        .en_i  (state_q == IDLE && !i_rst),
        .gnt_o (gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        gid_d = gid_q;
        a_d = a_q;
        b_d = b_q;
        op_d = op_q;
        out_d = out_q;
        st_d = st_q;
        unique case (state_q)
            IDLE: if (|gnt) begin
                gid_d = gnt[1];
                a_d = gnt[1] ? i_req1_a : i_req0_a;
                b_d = gnt[1] ? i_req1_b : i_req0_b;
                op_d = gnt[1] ? i_req1_op : i_req0_op;
                cnt_d = CNT_W'(EXE_LAT);
                state_d = WAIT;
            end
            // counter runs EXE_LAT..0 so WAIT spans EXE_LAT+1 cycles
            WAIT: if (cnt_q == '0) begin
                out_d = i_exe_out;
                st_d = i_exe_status;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            RESP: if (gid_q ? i_rsp1_ready : i_rsp0_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            gid_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            out_q <= '0;
            st_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            gid_q <= gid_d;
            a_q <= a_d;
            b_q <= b_d;
            op_q <= op_d;
            out_q <= out_d;
            st_q <= st_d;
        end
    end

    assign o_req0_ready = gnt[0];
    assign o_req1_ready = gnt[1];
    assign o_rsp0_valid = state_q == RESP && !gid_q;
    assign o_rsp1_valid = state_q == RESP && gid_q;
    assign o_rsp_out = out_q;
    assign o_rsp_status = st_q;
    assign o_exe_a = a_q;
    assign o_exe_b = b_q;
    assign o_exe_op = op_q;
    assign o_busy = state_q != IDLE;
endmodule

// File: tb/tb_exe_unit_arb.sv
// tb_exe_unit_arb: exe_unit_arb on a real exe_unit_w6, checked each cycle against a transaction-level model
module tb_exe_unit_arb;
    localparam int BITS = 8;
    localparam int LAT = 1;
    typedef struct packed {logic [7:0] a; logic [7:0] b; logic [1:0] op;} op_t;

    logic       i_clk = 0, i_rst = 1;
    logic       i_req0_valid = 0, i_req1_valid = 0, i_rsp0_ready = 0, i_rsp1_ready = 0;
    logic [7:0] i_req0_a = 0, i_req0_b = 0, i_req1_a = 0, i_req1_b = 0;
    logic [1:0] i_req0_op = 0, i_req1_op = 0;
    logic       o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_busy;
    logic [7:0] o_rsp_out, o_exe_a, o_exe_b, exe_out;
    logic [3:0] o_rsp_status, exe_status;
    logic [1:0] o_exe_op;

    int  nchk = 0, nerr = 0, cyc = 0;
    int  drsp [2];
    bit  mon = 0;
    bit  m_act = 0, m_gid = 0, m_rr = 0;
    int  m_acc = 0;
    logic [7:0] m_out = 0, m_ea = 0, m_eb = 0, m_res = 0;
    logic [3:0] m_st = 0, m_sts = 0;
    logic [1:0] m_eop = 0;
    op_t q0[$], q1[$];

    exe_unit_arb #(.BITS(BITS), .EXE_LAT(LAT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_op(i_req0_op),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_op(i_req1_op),
        .o_rsp0_valid(o_rsp0_valid), .o_rsp1_valid(o_rsp1_valid),
        .i_rsp0_ready(i_rsp0_ready), .i_rsp1_ready(i_rsp1_ready),
        .o_rsp_out(o_rsp_out), .o_rsp_status(o_rsp_status),
        .o_exe_a(o_exe_a), .o_exe_b(o_exe_b), .o_exe_op(o_exe_op),
        .i_exe_out(exe_out), .i_exe_status(exe_status), .o_busy(o_busy)
    );

    exe_unit_w6 #(.BITS(BITS), .EXE_LAT(LAT)) u_exe (
        .i_clk(i_clk), .i_a(o_exe_a), .i_b(o_exe_b), .i_op(o_exe_op),
        .o_out(exe_out), .o_status(exe_status)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // reference behaviour of exe_unit_w6 in plain integer arithmetic
    function automatic void ref_exe(input int a, input int b, input int op,
                                    output logic [7:0] r, output logic [3:0] s);
        int d, sd, f;
        d = a - b;
        sd = (a >= 128 ? a - 256 : a) - (b >= 128 ? b - 256 : b);
        r = 8'((op == 0) ? d : (op == 1) ? int'(a < b) : (op == 2) ? a << (b % 8) : a ^ (1 << (b % 8)));
        f = (op < 2) ? (d & 255) : int'(r);
        s = {f >= 128, f == 0, op < 2 && a < b, op < 2 && (sd < -128 || sd > 127)};
    endfunction

    // compare now, then advance the model to what the next rising edge must produce
    always @(negedge i_clk) begin : cmp
        bit r0, r1, rsp;
        rsp = m_act && cyc >= m_acc + LAT + 1;
        r0 = !i_rst && !m_act && i_req0_valid && (!i_req1_valid || !m_rr);
        r1 = !i_rst && !m_act && i_req1_valid && (!i_req0_valid || m_rr);
        if (mon) begin
            chk("req0_ready", o_req0_ready, r0);
            chk("req1_ready", o_req1_ready, r1);
            chk("busy", o_busy, m_act);
            chk("rsp0_valid", o_rsp0_valid, rsp && !m_gid);
            chk("rsp1_valid", o_rsp1_valid, rsp && m_gid);
            chk("rsp_out", o_rsp_out, m_out);
            chk("rsp_status", o_rsp_status, m_st);
            chk("exe_a", o_exe_a, m_ea);
            chk("exe_b", o_exe_b, m_eb);
            chk("exe_op", o_exe_op, m_eop);
            if (o_rsp0_valid && i_rsp0_ready) drsp[0]++;
            if (o_rsp1_valid && i_rsp1_ready) drsp[1]++;
        end
        if (i_rst) begin
            m_act = 0; m_rr = 0; m_out = 0; m_st = 0; m_ea = 0; m_eb = 0; m_eop = 0;
        end else if (r0 || r1) begin
            m_act = 1; m_gid = r1; m_acc = cyc + 1; m_rr = !r1;
            m_ea = r1 ? i_req1_a : i_req0_a;
            m_eb = r1 ? i_req1_b : i_req0_b;
            m_eop = r1 ? i_req1_op : i_req0_op;
            ref_exe(m_ea, m_eb, m_eop, m_res, m_sts);
        end else if (rsp && (m_gid ? i_rsp1_ready : i_rsp0_ready)) begin
            m_act = 0;
        end
        if (m_act && cyc + 1 == m_acc + LAT + 1) begin
            m_out = m_res;
            m_st = m_sts;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // present one or two requests and collect the responses; first is the ID granted first
    task automatic serve(input bit v0, input bit v1, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] op,
                         output logic [7:0] g0, output logic [7:0] g1, output int first);
        bit p0, p1, h0, h1;
        int n;
        i_req0_valid = v0; i_req0_a = a0; i_req0_b = b0; i_req0_op = op;
        i_req1_valid = v1; i_req1_a = a1; i_req1_b = b1; i_req1_op = op;
        i_rsp0_ready = 1; i_rsp1_ready = 1;
        p0 = v0; p1 = v1; first = -1; n = 0; g0 = 0; g1 = 0;
        while ((p0 || p1) && n < 40) begin
            @(negedge i_clk);
            h0 = i_req0_valid && o_req0_ready;
            h1 = i_req1_valid && o_req1_ready;
            if (first < 0 && h0) first = 0;
            if (first < 0 && h1) first = 1;
            if (o_rsp0_valid) begin g0 = o_rsp_out; p0 = 0; end
            if (o_rsp1_valid) begin g1 = o_rsp_out; p1 = 0; end
            tick();
            if (h0) i_req0_valid = 0;
            if (h1) i_req1_valid = 0;
            n++;
        end
        chk("serve_in_time", n < 40, 1);
    endtask

    initial begin
        logic [7:0] g0, g1;
        int first, n, c0, c1;
        bit h0, h1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 0;
        mon = 1;
        @(negedge i_clk);
        chk("reset_busy", o_busy, 0);
        chk("reset_rsp_out", o_rsp_out, 0);
        chk("reset_exe_a", o_exe_a, 0);
        tick();
        // single requester, latency and value pinned by hand
        i_req0_valid = 1; i_req0_a = 91; i_req0_b = 41; i_req0_op = 0;
        @(negedge i_clk);
        chk("t1_ready0", o_req0_ready, 1);
        tick();
        i_req0_valid = 0;
        @(negedge i_clk);
        chk("t1_wait_busy", o_busy, 1);
        chk("t1_exe_a", o_exe_a, 91);
        tick();
        @(negedge i_clk);
        chk("t1_no_rsp_yet", o_rsp0_valid, 0);
        tick();
        i_rsp0_ready = 1;
        @(negedge i_clk);
        chk("t1_rsp0_valid", o_rsp0_valid, 1);
        chk("t1_out", o_rsp_out, 50);
        chk("t1_status", o_rsp_status, 4'b0000);
        tick();
        @(negedge i_clk);
        chk("t1_done_valid", o_rsp0_valid, 0);
        chk("t1_done_busy", o_busy, 0);
        tick();
        // reset clears the pointer: contention goes to 0, then alternates
        i_rst = 1;
        tick();
        i_rst = 0;
        serve(1, 1, 10, 3, 20, 5, 2'd0, g0, g1, first);
        chk("pair1_first", first, 0);
        chk("pair1_out0", g0, 7);
        chk("pair1_out1", g1, 15);
        serve(1, 1, 30, 1, 40, 2, 2'd0, g0, g1, first);
        chk("pair2_first", first, 0);
        chk("pair2_out0", g0, 29);
        chk("pair2_out1", g1, 38);
        serve(1, 1, 8'h0F, 4, 8'hFF, 7, 2'd3, g0, g1, first);
        chk("pair3_first", first, 0);
        chk("pair3_out0", g0, 8'h1F);
        chk("pair3_out1", g1, 8'h7F);
        serve(1, 0, 3, 9, 0, 0, 2'd1, g0, g1, first);
        chk("cmp_out", g0, 1);
        // response back-pressure with requester 1 waiting
        i_rsp0_ready = 0;
        i_req0_valid = 1; i_req0_a = 5; i_req0_b = 9; i_req0_op = 0;
        @(negedge i_clk);
        chk("bp_ready0", o_req0_ready, 1);
        tick();
        i_req0_valid = 0;
        i_req1_valid = 1; i_req1_a = 7; i_req1_b = 1; i_req1_op = 0;
        tick();
        tick();
        repeat (5) begin
            @(negedge i_clk);
            chk("bp_valid", o_rsp0_valid, 1);
            chk("bp_out", o_rsp_out, 252);
            chk("bp_status", o_rsp_status, 4'b1010);
            chk("bp_busy", o_busy, 1);
            chk("bp_no_grant", o_req1_ready, 0);
            tick();
        end
        i_rsp0_ready = 1;
        @(negedge i_clk);
        tick();
        @(negedge i_clk);
        chk("bp_next_grant", o_req1_ready, 1);
        tick();
        i_req1_valid = 0;
        n = 0;
        while (o_busy && n < 10) begin
            @(negedge i_clk);
            tick();
            n++;
        end
        chk("bp_drain", o_busy, 0);
        // reset one cycle into WAIT abandons the operation
        i_req1_valid = 1; i_req1_a = 3; i_req1_b = 1; i_req1_op = 2;
        @(negedge i_clk);
        chk("rst_ready1", o_req1_ready, 1);
        tick();
        i_req1_valid = 0;
        i_rst = 1;
        tick();
        i_rst = 0;
        @(negedge i_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_out", o_rsp_out, 0);
        chk("rst_exe_a", o_exe_a, 0);
        chk("rst_exe_op", o_exe_op, 0);
        tick();
        repeat (4) begin
            @(negedge i_clk);
            chk("rst_no_rsp", o_rsp1_valid, 0);
            tick();
        end
        serve(0, 1, 0, 0, 3, 1, 2'd2, g0, g1, first);
        chk("after_rst_out1", g1, 6);
        // random traffic with withdrawals and response stalls
        for (int i = 0; i < 500; i++) begin
            q0.push_back({8'($urandom), 8'($urandom), 2'($urandom)});
            q1.push_back({8'($urandom), 8'($urandom), 2'($urandom)});
        end
        c0 = drsp[0];
        c1 = drsp[1];
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || o_busy) && n < 40000) begin
            @(negedge i_clk);
            h0 = i_req0_valid && o_req0_ready;
            h1 = i_req1_valid && o_req1_ready;
            tick();
            n++;
            if (h0) begin void'(q0.pop_front()); i_req0_valid = 0; end
            else if ($urandom_range(15) == 0) i_req0_valid = 0;
            if (h1) begin void'(q1.pop_front()); i_req1_valid = 0; end
            else if ($urandom_range(15) == 0) i_req1_valid = 0;
            if (!i_req0_valid && q0.size() > 0 && $urandom_range(1) == 1) begin
                i_req0_valid = 1; {i_req0_a, i_req0_b, i_req0_op} = q0[0];
            end
            if (!i_req1_valid && q1.size() > 0 && $urandom_range(1) == 1) begin
                i_req1_valid = 1; {i_req1_a, i_req1_b, i_req1_op} = q1[0];
            end
            i_rsp0_ready = $urandom_range(3) != 0;
            i_rsp1_ready = $urandom_range(3) != 0;
        end
        chk("rnd_in_time", n < 40000, 1);
        chk("rnd_rsp0_count", drsp[0] - c0, 500);
        chk("rnd_rsp1_count", drsp[1] - c1, 500);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
